regfile_write_bank: RTL and testbench

- Write side of the CPU's 32x32 register file: the storage and address-decode end whose contents the read-port multiplexers select from.
- Accepts write requests through a valid/ready handshake and stages each one for a cycle.
- Decodes the 5-bit address to one-hot write enables and updates the addressed register.
- Exposes all 32 registers as one flat bus for the read muxes. Also provides a sequenced clear operation that zeroes the file.

---
 rtl/regfile_write_bank_pkg.sv | 22 ++
 rtl/regfile_write_bank_if.sv | 19 +
 rtl/regfile_write_bank_decoder1to32.sv | 18 +
 rtl/regfile_write_bank.sv | 124 ++++++++++++
 tb/tb_regfile_write_bank.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_bank_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | regfile_write_bank_pkg : shared sizes, states and constants            |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
package regfile_write_bank_pkg;

   localparam int REG_COUNT  = 32;
   localparam int REG_ADDR_W = 5;
   localparam int REG_WIDTH  = 32;
   localparam int WRCOUNT_W  = 16;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   // The clear counter starts at 1, so its final value equals the cycle count.
   localparam logic [REG_ADDR_W-1:0] CLR_CYCLES = 5'd31;

endpackage : regfile_write_bank_pkg
`default_nettype wire

// File: rtl/regfile_write_bank_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | regfile_write_bank_if : valid/ready write-request bus                  |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
interface regfile_write_bank_if
   import regfile_write_bank_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH
);
   logic                  wr_valid;
   logic                  wr_ready;
   logic [REG_ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]      wr_data;

   modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface : regfile_write_bank_if
`default_nettype wire

// File: rtl/regfile_write_bank_decoder1to32.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | decoder1to32 : 5-bit index to gated one-hot enable (combinational)     |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module decoder1to32
   import regfile_write_bank_pkg::*;
(
   input  wire                   i_en,
   input  wire  [REG_ADDR_W-1:0] i_addr,
   output logic [REG_COUNT-1:0]  o_onehot
);
   always_comb begin
      o_onehot         = '0;
      o_onehot[i_addr] = i_en;
   end
endmodule : decoder1to32
`default_nettype wire

// File: rtl/regfile_write_bank.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | regfile_write_bank : staged-write side of the 32x32 register file      |
// | Optional wr_count output enabled by macro REGFILE_WRCOUNT_EN.          |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module regfile_write_bank
   import regfile_write_bank_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH,
   parameter int DEPTH = REG_COUNT
)
(
   input  wire                      clk,
   input  wire                      reset_n,
   regfile_write_bank_if.slave      wr,
   input  wire                      clr_req,
   output logic                     clr_busy,
   output logic                     commit_pulse,
   output logic [REG_ADDR_W-1:0]    commit_addr,
   output logic [WIDTH*DEPTH-1:0]   regs_flat
`ifdef REGFILE_WRCOUNT_EN
   ,
   output logic [WRCOUNT_W-1:0]     wr_count
`endif
);

   state_t                r_state;
   state_t                w_state_next;
   logic                  r_stg_valid;
   logic [REG_ADDR_W-1:0] r_stg_addr;
   logic [WIDTH-1:0]      r_stg_data;
   logic [REG_ADDR_W-1:0] r_clr_cnt;
   logic                  w_accept;
   logic                  w_clr_active;
   logic                  w_clr_last;
   logic [REG_COUNT-1:0]  w_commit_en;
   logic [REG_COUNT-1:0]  w_clear_en;
   logic                  w_unused_bit0;

   // clr_req outranks a simultaneous write request
   assign wr.wr_ready  = reset_n && (r_state == ST_IDLE) && !clr_req;
   assign w_accept     = wr.wr_valid && wr.wr_ready;
   assign w_clr_active = (r_state == ST_CLEAR);
   assign w_clr_last   = (r_clr_cnt == CLR_CYCLES);

   assign clr_busy     = w_clr_active;
   assign commit_pulse = r_stg_valid;
   assign commit_addr  = r_stg_addr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (clr_req)    w_state_next = ST_CLEAR;
         ST_CLEAR: if (w_clr_last) w_state_next = ST_IDLE;
         default:                  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stg_valid <= 1'b0;
         r_stg_addr  <= '0;
         r_stg_data  <= '0;
      end else begin
         r_stg_valid <= w_accept;
         if (w_accept) begin
            r_stg_addr <= wr.wr_addr;
            r_stg_data <= wr.wr_data;
         end
      end
   end

   // Preloaded with 1 while idle so the first clear cycle targets r1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                r_clr_cnt <= '0;
      else if (r_state == ST_IDLE) r_clr_cnt <= 5'd1;
      else                         r_clr_cnt <= r_clr_cnt + 5'd1;
   end

   decoder1to32 u_dec_commit (
      .i_en     (r_stg_valid),
      .i_addr   (r_stg_addr),
      .o_onehot (w_commit_en)
   );

   decoder1to32 u_dec_clear (
      .i_en     (w_clr_active),
      .i_addr   (r_clr_cnt),
      .o_onehot (w_clear_en)
   );

   // r0 has no storage, so its decode lines go nowhere
   assign w_unused_bit0        = w_commit_en[0] | w_clear_en[0];
   assign regs_flat[WIDTH-1:0] = '0;

   for (genvar r = 1; r < DEPTH; r++) begin : g_reg
      logic [WIDTH-1:0] r_q;
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)            r_q <= '0;
         else if (w_clear_en[r])  r_q <= '0;
         else if (w_commit_en[r]) r_q <= r_stg_data;
      end
      assign regs_flat[WIDTH*r +: WIDTH] = r_q;
   end

`ifdef REGFILE_WRCOUNT_EN
   logic [WRCOUNT_W-1:0] r_wr_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)         r_wr_count <= '0;
      else if (r_stg_valid) r_wr_count <= r_wr_count + 16'd1;
   end

   assign wr_count = r_wr_count;
`endif

endmodule : regfile_write_bank
`default_nettype wire

// File: tb/tb_regfile_write_bank.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_regfile_write_bank : vector table plus commit scoreboard            |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_regfile_write_bank;
   import regfile_write_bank_pkg::*;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          clr_req;
   logic          clr_busy;
   logic          commit_pulse;
   logic [4:0]    commit_addr;
   logic [1023:0] regs_flat;
`ifdef REGFILE_WRCOUNT_EN
   logic [15:0]   wr_count;
`endif

   regfile_write_bank_if #(.WIDTH(32)) wif ();

   always #5 clk = ~clk;

   regfile_write_bank dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr           (wif),
      .clr_req      (clr_req),
      .clr_busy     (clr_busy),
      .commit_pulse (commit_pulse),
      .commit_addr  (commit_addr),
      .regs_flat    (regs_flat)
`ifdef REGFILE_WRCOUNT_EN
      ,
      .wr_count     (wr_count)
`endif
   );

   typedef struct {
      logic        v;
      logic [4:0]  a;
      logic [31:0] d;
      logic        clr;
      logic        exp_ready;
   } vec_t;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t         q[$];
   logic [31:0] m_regs [32];
   int          m_clr_left = 0;
   int          m_count    = 0;
   int          busy_seen  = 0;
   int          errors     = 0;
   int          checks     = 0;
   vec_t        vt [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_regs(input string name);
      int bad = -1;
      checks++;
      for (int r = 0; r < 32; r++)
         if (bad < 0 && regs_flat[32*r +: 32] !== m_regs[r]) bad = r;
      if (bad >= 0) begin
         errors++;
         $display("FAIL %s: r%0d got 0x%08h, expected 0x%08h",
                  name, bad, regs_flat[32*bad +: 32], m_regs[bad]);
      end
   endtask

   function automatic logic m_ready(input logic clr);
      return (m_clr_left == 0) && !clr;
   endfunction

   // One clock: drive, check this cycle's outputs, then advance the model past the edge.
   task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic clr, input logic exp_ready, input string tag);
      wr_t e;
      @(negedge clk);
      wif.wr_valid = v;
      wif.wr_addr  = a;
      wif.wr_data  = d;
      clr_req      = clr;
      #1;
      chk_regs({tag, ".regs"});
`ifdef REGFILE_WRCOUNT_EN
      chk({tag, ".wr_count"}, 32'(wr_count), 32'(m_count[15:0]));
`endif
      chk({tag, ".commit_pulse"}, 32'(commit_pulse), 32'(q.size() != 0));
      if (q.size() != 0) begin
         e = q.pop_front();
         chk({tag, ".commit_addr"}, 32'(commit_addr), 32'(e.a));
         if (e.a != 5'd0) m_regs[e.a] = e.d;
         m_count++;
      end
      chk({tag, ".wr_ready"}, 32'(wif.wr_ready), 32'(exp_ready));
      chk({tag, ".clr_busy"}, 32'(clr_busy), 32'(m_clr_left != 0));
      if (clr_busy === 1'b1) busy_seen++;
      if (v && exp_ready) q.push_back('{a: a, d: d});
      if (m_clr_left != 0) begin
         m_regs[32 - m_clr_left] = '0;
         m_clr_left--;
      end else if (clr) begin
         m_clr_left = 31;
      end
   endtask

   task automatic model_reset();
      q.delete();
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      m_clr_left = 0;
      m_count    = 0;
   endtask

   // Reset lands mid-cycle, away from any clock edge.
   task automatic do_reset(input string tag);
      @(negedge clk);
      wif.wr_valid = 1'b0;
      clr_req      = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      chk_regs({tag, ".regs"});
      chk({tag, ".clr_busy"}, 32'(clr_busy), 32'd0);
      chk({tag, ".commit_pulse"}, 32'(commit_pulse), 32'd0);
      chk({tag, ".commit_addr"}, 32'(commit_addr), 32'd0);
      chk({tag, ".wr_ready"}, 32'(wif.wr_ready), 32'd0);
`ifdef REGFILE_WRCOUNT_EN
      chk({tag, ".wr_count"}, 32'(wr_count), 32'd0);
`endif
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n      = 1'b0;
      clr_req      = 1'b0;
      wif.wr_valid = 1'b0;
      wif.wr_addr  = '0;
      wif.wr_data  = '0;
      model_reset();

      vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1};
      vt[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1};
      vt[2] = '{1'b1, 5'd1, 32'h11,       1'b0, 1'b1};
      vt[3] = '{1'b1, 5'd2, 32'h22,       1'b0, 1'b1};
      vt[4] = '{1'b1, 5'd1, 32'h33,       1'b0, 1'b1};
      vt[5] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1};
      vt[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1};
      vt[7] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1};

      repeat (2) @(negedge clk);
      #1;
      chk_regs("reset.regs");
      chk("reset.wr_ready", 32'(wif.wr_ready), 32'd0);
      chk("reset.clr_busy", 32'(clr_busy), 32'd0);
      chk("reset.commit_pulse", 32'(commit_pulse), 32'd0);
      chk("reset.commit_addr", 32'(commit_addr), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++)
         step(vt[i].v, vt[i].a, vt[i].d, vt[i].clr, vt[i].exp_ready, $sformatf("vec%0d", i));
      chk("final.r5", regs_flat[191:160], 32'hDEADBEEF);
      chk("final.r1", regs_flat[63:32], 32'h33);
      chk("final.r2", regs_flat[95:64], 32'h22);
      chk("final.r0", regs_flat[31:0], 32'h0);

      // Fill r1..r31, then clear while a write to r7 is offered.
      for (int i = 1; i < 32; i++)
         step(1'b1, 5'(i), 32'(i), 1'b0, 1'b1, "fill");
      busy_seen = 0;
      step(1'b1, 5'd7, 32'h77, 1'b1, 1'b0, "clr_start");
      for (int i = 0; i < 31; i++)
         step(1'b0, 5'd0, 32'h0, 1'b0, m_ready(1'b0), "clr_run");
      step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, "clr_done");
      chk("clr.busy_cycles", 32'(busy_seen), 32'(CLR_CYCLES));
      checks++;
      if (regs_flat !== '0) begin
         errors++;
         $display("FAIL clr.all_zero: got nonzero file, expected all zero");
      end

      // clr_req held throughout: ignored while busy, restarts on return to idle.
      step(1'b1, 5'd4, 32'hA5A5A5A5, 1'b0, 1'b1, "pre_hold");
      busy_seen = 0;
      for (int i = 0; i < 33; i++)
         step(1'b1, 5'd6, 32'h66, 1'b1, m_ready(1'b1), "clr_hold");
      while (m_clr_left != 0)
         step(1'b0, 5'd0, 32'h0, 1'b0, m_ready(1'b0), "clr_tail");
      step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, "hold_done");
      chk("hold.busy_cycles", 32'(busy_seen), 32'd62);

      // Reset during clear cycle 10.
      step(1'b1, 5'd3, 32'h0BADF00D, 1'b0, 1'b1, "pre_rst");
      step(1'b1, 5'd30, 32'h12345678, 1'b0, 1'b1, "pre_rst");
      step(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "rst_clr_start");
      for (int i = 0; i < 10; i++)
         step(1'b0, 5'd0, 32'h0, 1'b0, m_ready(1'b0), "rst_clr_run");
      do_reset("mid_clear");
      step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, "post_rst");

      // Reset with a write still staged: it must never land.
      step(1'b1, 5'd9, 32'h99, 1'b0, 1'b1, "stage");
      do_reset("staged");
      step(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, "post_rst2");
      chk("staged.r9", regs_flat[319:288], 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_regfile_write_bank
`default_nettype wire
